// File: rtl/riscboy_pkg.sv
// Definitions shared across riscboy peripherals: the SPI target state encoding
// and the byte width used on its receive path.
package riscboy_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } spi_state_e;

endpackage

// File: rtl/lcd_spi_target_sync_fifo.sv
// Single-clock FIFO with registered write. Each pointer has one extra MSB so
// full and empty can be told apart. A pushed word becomes visible the cycle after it is written.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the head slot, so a push to a full FIFO still lands.
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/lcd_spi_target.sv
// Receive-only SPI mode 0 target for an LCD controller port. It synchronises the pins,
// assembles bytes MSB first and queues {dc, byte} for a valid/ready consumer.
module lcd_spi_target
    import riscboy_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_scl,
    input  logic                          spi_sda,
    input  logic                          spi_cs_n,
    input  logic                          spi_dc,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [BYTE_W-1:0]             rx_data,
    output logic                          rx_dc,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          active
);
    // Handshake: a byte leaves the FIFO on any cycle where rx_valid && rx_ready; the head
    // (rx_data, rx_dc) holds steady while rx_valid is high and rx_ready is low.

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q, cs_sync_q, dc_sync_q;
    logic                   scl_prev_q, cs_prev_q;
    logic                   scl_s, sda_s, cs_s, dc_s;
    logic                   scl_rise, cs_fall, cs_rise;

    spi_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]      shift_q, shift_d;
    logic                   push;
    logic [BYTE_W:0]        push_data;
    logic [BYTE_W:0]        head;
    logic                   drop;
    logic                   overflow_q, overflow_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            cs_sync_q  <= '1;
            dc_sync_q  <= '0;
            scl_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], spi_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], spi_sda};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            dc_sync_q  <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
            scl_prev_q <= scl_s;
            cs_prev_q  <= cs_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign dc_s     = dc_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // Deselect wins over a coincident clock edge, so a partial byte is simply dropped.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        push_data = {dc_s, shift_q, sda_s};
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = '0;
                end
            end
            ST_RECV: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (scl_rise) begin
                    shift_d   = {shift_q[BYTE_W-3:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    push      = (bit_cnt_q == 3'd7);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (BYTE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (rx_ready),
        .valid_o     (rx_valid),
        .data_o      (head),
        .level_o     (level),
        .drop_o      (drop)
    );

    assign rx_data  = head[BYTE_W-1:0];
    assign rx_dc    = head[BYTE_W];
    assign overflow = overflow_q;
    assign active   = (state_q == ST_RECV);

endmodule

// File: tb/tb_lcd_spi_target.sv
// Bench for lcd_spi_target: a transaction-level queue model of the received bytes,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_lcd_spi_target;

    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;
    // Cycles from a pin change (driven just after an edge) to its effect being visible.
    localparam int LAT         = SYNC_STAGES + 1;

    typedef struct {
        int         cyc;
        bit         is_act;
        logic [8:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst, spi_scl, spi_sda, spi_cs_n, spi_dc;
    logic          rx_valid, rx_ready, rx_dc, overflow, overflow_clr, active;
    logic [7:0]    rx_data;
    logic [LW-1:0] level;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            rand_mode = 1'b0;
    int            ready_thresh = 2;

    logic [8:0]    exp_q[$];
    ev_t           ev_q[$];
    logic          m_over = 1'b0;
    logic          m_active = 1'b0;

    lcd_spi_target #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_scl      (spi_scl),
        .spi_sda      (spi_sda),
        .spi_cs_n     (spi_cs_n),
        .spi_dc       (spi_dc),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_dc        (rx_dc),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .active       (active)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void sched(input bit is_act, input logic [8:0] d);
        ev_t e;
        e.cyc    = cyc + LAT;
        e.is_act = is_act;
        e.data   = d;
        ev_q.push_back(e);
    endfunction

    // Scoreboard: a byte queue updated per clock edge, then compared 1 time unit later.
    always @(posedge clk) begin
        ev_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            ev_q.delete();
            m_over   = 1'b0;
            m_active = 1'b0;
        end else begin
            if (rx_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (overflow_clr) m_over = 1'b0;
            while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                e = ev_q.pop_front();
                if (e.is_act) m_active = e.data[0];
                else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e.data);
                else m_over = 1'b1;
            end
        end
        #1;
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_q.size() > 0});
        chk("level", {{(32-LW){1'b0}}, level}, exp_q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_over});
        chk("active", {31'd0, active}, {31'd0, m_active});
        if (exp_q.size() > 0) begin
            chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q[0][7:0]});
            chk("rx_dc", {31'd0, rx_dc}, {31'd0, exp_q[0][8]});
        end
        if (rst) begin
            chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
            chk("rst_rx_dc", {31'd0, rx_dc}, 32'd0);
        end
    end

    // Consumer stimulus used in the randomized phase
    always @(posedge clk) begin
        #2;
        if (rand_mode) begin
            rx_ready     = ($urandom_range(0, 3) < ready_thresh);
            overflow_clr = ($urandom_range(0, 7) == 0);
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cs_low();
        tick(1);
        spi_cs_n = 1'b0;
        sched(1'b1, 9'd1);
        tick(LAT + 2);
    endtask

    task automatic cs_high();
        tick(2);
        spi_cs_n = 1'b1;
        sched(1'b1, 9'd0);
        tick(LAT + 2);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits, input bit pop_on_push);
        spi_dc = dc;
        for (int i = 0; i < nbits; i++) begin
            spi_sda = b[7-i];
            tick($urandom_range(2, 4));
            spi_scl = 1'b1;
            if (i == 7) sched(1'b0, {dc, b});
            if (i == 7 && pop_on_push) begin
                tick(LAT - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end else begin
                tick($urandom_range(2, 4));
            end
            spi_scl = 1'b0;
        end
    endtask

    task automatic pop_expect(input string name, input logic [8:0] exp);
        chk({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({name, "_data"}, {24'd0, rx_data}, {24'd0, exp[7:0]});
        chk({name, "_dc"}, {31'd0, rx_dc}, {31'd0, exp[8]});
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget   = 400;
        rx_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries still queued, required 0", exp_q.size());
        end
        tick(1);
        rx_ready = 1'b0;
        chk("drain_level", {{(32-LW){1'b0}}, level}, 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        rst          = 1'b1;
        spi_scl      = 1'b0;
        spi_sda      = 1'b0;
        spi_cs_n     = 1'b1;
        spi_dc       = 1'b0;
        rx_ready     = 1'b0;
        overflow_clr = 1'b0;
        tick(3);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_level", {{(32-LW){1'b0}}, level}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_active", {31'd0, active}, 32'd0);
        chk("reset_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Single data byte
        cs_low();
        chk("a5_active", {31'd0, active}, 32'd1);
        send_bits(8'hA5, 1'b1, 8, 1'b0);
        cs_high();
        chk("a5_level", {{(32-LW){1'b0}}, level}, 32'd1);
        pop_expect("a5", 9'h1A5);
        chk("a5_level_after", {{(32-LW){1'b0}}, level}, 32'd0);

        // Three back-to-back bytes, mixed dc
        cs_low();
        send_bits(8'h2A, 1'b0, 8, 1'b0);
        send_bits(8'h00, 1'b1, 8, 1'b0);
        send_bits(8'hFF, 1'b1, 8, 1'b0);
        cs_high();
        chk("three_level", {{(32-LW){1'b0}}, level}, 32'd3);
        pop_expect("three_0", 9'h02A);
        pop_expect("three_1", 9'h100);
        pop_expect("three_2", 9'h1FF);

        // Overflow with five bytes and no consumer
        cs_low();
        for (int i = 1; i <= 5; i++) send_bits(8'(i), 1'b0, 8, 1'b0);
        cs_high();
        chk("ovf_level", {{(32-LW){1'b0}}, level}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 1; i <= 4; i++) pop_expect("ovf_pop", 9'(i));

        // Partial byte discarded on deselect
        cs_low();
        send_bits(8'hF0, 1'b1, 5, 1'b0);
        cs_high();
        chk("partial_level", {{(32-LW){1'b0}}, level}, 32'd0);
        cs_low();
        send_bits(8'h3C, 1'b0, 8, 1'b0);
        cs_high();
        chk("partial_next_level", {{(32-LW){1'b0}}, level}, 32'd1);
        chk("partial_overflow", {31'd0, overflow}, 32'd0);
        pop_expect("partial_3c", 9'h03C);

        // Push into a full FIFO with a simultaneous pop
        cs_low();
        for (int i = 1; i <= 4; i++) send_bits(8'h10 + 8'(i), 1'b0, 8, 1'b0);
        send_bits(8'h55, 1'b1, 8, 1'b1);
        cs_high();
        chk("full_pop_level", {{(32-LW){1'b0}}, level}, 32'd4);
        chk("full_pop_overflow", {31'd0, overflow}, 32'd0);
        pop_expect("full_pop_0", 9'h012);
        pop_expect("full_pop_1", 9'h013);
        pop_expect("full_pop_2", 9'h014);
        pop_expect("full_pop_3", 9'h155);

        // Reset in the middle of a byte with data queued
        cs_low();
        send_bits(8'h66, 1'b0, 8, 1'b0);
        send_bits(8'h77, 1'b1, 8, 1'b0);
        tick(LAT + 1);
        chk("mid_rst_level_before", {{(32-LW){1'b0}}, level}, 32'd2);
        send_bits(8'h99, 1'b0, 3, 1'b0);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_level", {{(32-LW){1'b0}}, level}, 32'd0);
        chk("mid_rst_active", {31'd0, active}, 32'd0);
        spi_cs_n = 1'b1;
        spi_scl  = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post_rst_active", {31'd0, active}, 32'd0);
        cs_low();
        send_bits(8'h81, 1'b1, 8, 1'b0);
        cs_high();
        chk("post_rst_level", {{(32-LW){1'b0}}, level}, 32'd1);
        pop_expect("post_rst_81", 9'h181);

        // Randomized transfers with a random consumer
        rand_mode = 1'b1;
        repeat (30) begin
            ready_thresh = $urandom_range(0, 4);
            cs_low();
            repeat ($urandom_range(1, 6)) begin
                rb = 8'($urandom_range(0, 255));
                send_bits(rb, 1'($urandom_range(0, 1)), 8, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) begin
                rb = 8'($urandom_range(0, 255));
                send_bits(rb, 1'($urandom_range(0, 1)), $urandom_range(1, 7), 1'b0);
            end
            cs_high();
        end
        rand_mode = 1'b0;
        tick(1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
